video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
- Raster timing generator for the video output path; sits directly downstream of the mode constants in the xv package.
- Produces horizontal/vertical pixel counters, sync, blank and visible strobes, and the scanline status word.
- Consumed by the display fetch/pixel pipeline and by the AUX_VID_R_SCANLINE read path.
- All outputs are registered and mutually consistent: they always describe the same pixel position.

Parameters:
VISIBLE_WIDTH, 640, active pixels per line
VISIBLE_HEIGHT, 480, active lines per frame
H_FRONT_PORCH, 16, pixels after active before hsync
H_SYNC_PULSE, 96, hsync width in pixels
H_BACK_PORCH, 48, pixels after hsync
V_FRONT_PORCH, 10, lines after active before vsync
V_SYNC_PULSE, 2, vsync width in lines
V_BACK_PORCH, 33, lines after vsync
H_SYNC_POLARITY, 1'b0, active level of hsync_o
V_SYNC_POLARITY, 1'b0, active level of vsync_o

Ports:
clk  in  1  pixel clock
reset_n  in  1  asynchronous reset, active low
pix_ce_i  in  1  pixel advance enable; counters step only when high
h_count_o  out  11  current pixel column, 0..TOTAL_WIDTH-1
v_count_o  out  11  current line, 0..TOTAL_HEIGHT-1
visible_o  out  1  high when h < VISIBLE_WIDTH and v < VISIBLE_HEIGHT
h_blank_o  out  1  high when h >= VISIBLE_WIDTH
v_blank_o  out  1  high when v >= VISIBLE_HEIGHT
hsync_o  out  1  horizontal sync, polarity per H_SYNC_POLARITY
vsync_o  out  1  vertical sync, polarity per V_SYNC_POLARITY
end_of_line_o  out  1  level: h_count_o == TOTAL_WIDTH-1
frame_start_o  out  1  single-clk pulse when counters wrap to (0,0)
scanline_o  out  16  {v_blank, h_blank, 3'b000, v_count[10:0]} (AUX_VID_R_SCANLINE format)

Behaviour:
- Clocking and reset:
  - One clock domain (clk).
  - reset_n is asynchronous and active low, and clears all state immediately.
- Derived widths: TOTAL_WIDTH = sum of horizontal params; TOTAL_HEIGHT = sum of vertical params. Both must be <= 2048; enforce with an elaboration-time check.
- Line ordering:
  - Horizontal: active [0, VW), front porch, sync [VW+HFP, VW+HFP+HSP), back porch.
  - Vertical: same ordering with the V parameters.
- Reset values: h_count_o=0, v_count_o=0, visible_o=1, h_blank_o=0, v_blank_o=0, hsync_o=~H_SYNC_POLARITY, vsync_o=~V_SYNC_POLARITY, end_of_line_o=0, frame_start_o=0, scanline_o=16'h0000.
- Advance, on a clk edge with pix_ce_i=1:
  - h increments.
  - At h==TOTAL_WIDTH-1, h wraps to 0 and v increments.
  - At v==TOTAL_HEIGHT-1 with h==TOTAL_WIDTH-1, v wraps to 0.
- pix_ce_i=0: all counters and level outputs hold; frame_start_o is 0.
- Output decode:
  - Flags are computed from next-state counter values and registered in the same edge as the counters. Zero latency between h_count_o/v_count_o and the flags.
  - Blanks, syncs and end_of_line_o are pure functions of the registered position.
  - hsync is active on every line, including vertical blank lines.
- frame_start_o:
  - High for exactly one clk, on the edge where counters move from (TOTAL_WIDTH-1, TOTAL_HEIGHT-1) to (0,0).
  - Never asserted by reset itself.
- Timing: no combinational path from any input to any output.
- pix_ce_i toggling: with pix_ce_i toggling 1/0, each pixel spans 2 clks and level outputs stay stable across both. This supports pixel doubling.
- Reset mid-frame: outputs return to reset values asynchronously. On the first clk edge after release with pix_ce_i=1, h=1.

Test Plan:
- Reset, then hold pix_ce_i=1 with defaults:
  - h_count_o counts 0..799 then wraps to 0.
  - v_count_o increments on the wrap.
  - end_of_line_o is high only at h=799.
- Horizontal sync and blank:
  - hsync_o=0 exactly for h 656..751 (96 clks), 1 otherwise.
  - h_blank_o=1 for h 640..799.
- Full frame:
  - frame_start_o pulses once every 420000 clks.
  - vsync_o=0 exactly on lines 490..491.
  - v_blank_o=1 on lines 480..524.
  - visible_o counts 307200 high clks per frame.
- pix_ce_i alternating 1/0:
  - One line takes 1600 clks.
  - Outputs are stable when pix_ce_i=0.
  - frame_start_o is still a single-clk pulse.
- Scanline word:
  - At v=481, h=700, scanline_o = 16'hC1E1.
  - At v=10, h=5, scanline_o = 16'h000A.
- Reset during the vsync line (v=490):
  - Outputs immediately take reset values, vsync_o=1.
  - After release with 5 enabled clks, h_count_o=5, v_count_o=0.

Source files
------------

// File: rtl/video_timing_gen_if.sv
// rtl/video_timing_gen_if.sv - raster position and strobe bundle driven by video_timing_gen
//
// master : the timing generator, drives every signal
// slave  : fetch/pixel pipeline and scanline read path, observe only
//
//   h_count_o      11  current pixel column
//   v_count_o      11  current line
//   visible_o       1  inside the active window
//   h_blank_o       1  column outside the active width
//   v_blank_o       1  line outside the active height
//   hsync_o         1  horizontal sync at the configured polarity
//   vsync_o         1  vertical sync at the configured polarity
//   end_of_line_o   1  last column of the line
//   frame_start_o   1  one-clock pulse on the wrap to (0,0)
//   scanline_o     16  {v_blank, h_blank, 3'b000, v_count}
interface video_timing_gen_if;
    logic [10:0] h_count_o;
    logic [10:0] v_count_o;
    logic        visible_o;
    logic        h_blank_o;
    logic        v_blank_o;
    logic        hsync_o;
    logic        vsync_o;
    logic        end_of_line_o;
    logic        frame_start_o;
    logic [15:0] scanline_o;

    modport master (
        output h_count_o,
        output v_count_o,
        output visible_o,
        output h_blank_o,
        output v_blank_o,
        output hsync_o,
        output vsync_o,
        output end_of_line_o,
        output frame_start_o,
        output scanline_o
    );

    modport slave (
        input h_count_o,
        input v_count_o,
        input visible_o,
        input h_blank_o,
        input v_blank_o,
        input hsync_o,
        input vsync_o,
        input end_of_line_o,
        input frame_start_o,
        input scanline_o
    );
endinterface

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator: pixel counters, sync, blank and scanline word
//
// Ports:
//   clk       in   pixel clock
//   reset_n   in   asynchronous reset, active low
//   pix_ce_i  in   pixel advance enable; the raster steps only when high
//   vt        out  video_timing_gen_if.master, all timing outputs (registered)
//
// Each line is ordered active, front porch, sync, back porch; the frame uses
// the same ordering with the vertical parameters. Every output is a flop
// loaded on the same edge from the next-state position, so counters and
// flags always describe the same pixel.
module video_timing_gen #(
    parameter int   VISIBLE_WIDTH   = 640,
    parameter int   VISIBLE_HEIGHT  = 480,
    parameter int   H_FRONT_PORCH   = 16,
    parameter int   H_SYNC_PULSE    = 96,
    parameter int   H_BACK_PORCH    = 48,
    parameter int   V_FRONT_PORCH   = 10,
    parameter int   V_SYNC_PULSE    = 2,
    parameter int   V_BACK_PORCH    = 33,
    parameter logic H_SYNC_POLARITY = 1'b0,
    parameter logic V_SYNC_POLARITY = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pix_ce_i,
    video_timing_gen_if.master    vt
);

    localparam int TOTAL_WIDTH  = VISIBLE_WIDTH + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
    localparam int TOTAL_HEIGHT = VISIBLE_HEIGHT + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;

    // Counters are 11 bits wide, so neither dimension may exceed 2048.
    if (TOTAL_WIDTH > 2048 || TOTAL_HEIGHT > 2048 || TOTAL_WIDTH < 1 || TOTAL_HEIGHT < 1) begin : g_bad_geometry
        $error("video_timing_gen: raster totals must be in 1..2048");
    end

    // Boundaries held one bit wider than the counters so a full 2048 total
    // still compares correctly against a zero-extended count.
    localparam logic [11:0] H_ACTIVE_END = 12'(VISIBLE_WIDTH);
    localparam logic [11:0] H_SYNC_START = 12'(VISIBLE_WIDTH + H_FRONT_PORCH);
    localparam logic [11:0] H_SYNC_END   = 12'(VISIBLE_WIDTH + H_FRONT_PORCH + H_SYNC_PULSE);
    localparam logic [11:0] H_LAST       = 12'(TOTAL_WIDTH - 1);
    localparam logic [11:0] V_ACTIVE_END = 12'(VISIBLE_HEIGHT);
    localparam logic [11:0] V_SYNC_START = 12'(VISIBLE_HEIGHT + V_FRONT_PORCH);
    localparam logic [11:0] V_SYNC_END   = 12'(VISIBLE_HEIGHT + V_FRONT_PORCH + V_SYNC_PULSE);
    localparam logic [11:0] V_LAST       = 12'(TOTAL_HEIGHT - 1);

    logic [10:0] h_count_q, h_count_d;
    logic [10:0] v_count_q, v_count_d;
    logic        visible_q, visible_d;
    logic        h_blank_q, h_blank_d;
    logic        v_blank_q, v_blank_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        end_of_line_q, end_of_line_d;
    logic        frame_start_q, frame_start_d;
    logic [15:0] scanline_q, scanline_d;

    logic        h_at_last;
    logic        v_at_last;
    logic        h_in_sync;
    logic        v_in_sync;

    always_comb begin
        h_count_d     = h_count_q;
        v_count_d     = v_count_q;
        frame_start_d = 1'b0;

        h_at_last = ({1'b0, h_count_q} == H_LAST);
        v_at_last = ({1'b0, v_count_q} == V_LAST);

        if (pix_ce_i) begin
            if (h_at_last) begin
                h_count_d = '0;
                if (v_at_last) begin
                    v_count_d     = '0;
                    frame_start_d = 1'b1;
                end else begin
                    v_count_d = v_count_q + 11'd1;
                end
            end else begin
                h_count_d = h_count_q + 11'd1;
            end
        end

        // Decode from the next position so the registered flags line up
        // with the registered counters without an extra pipeline stage.
        h_blank_d     = ({1'b0, h_count_d} >= H_ACTIVE_END);
        v_blank_d     = ({1'b0, v_count_d} >= V_ACTIVE_END);
        visible_d     = ~h_blank_d & ~v_blank_d;
        h_in_sync     = ({1'b0, h_count_d} >= H_SYNC_START) && ({1'b0, h_count_d} < H_SYNC_END);
        v_in_sync     = ({1'b0, v_count_d} >= V_SYNC_START) && ({1'b0, v_count_d} < V_SYNC_END);
        hsync_d       = h_in_sync ? H_SYNC_POLARITY : ~H_SYNC_POLARITY;
        vsync_d       = v_in_sync ? V_SYNC_POLARITY : ~V_SYNC_POLARITY;
        end_of_line_d = ({1'b0, h_count_d} == H_LAST);
        scanline_d    = {v_blank_d, h_blank_d, 3'b000, v_count_d};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_count_q     <= '0;
            v_count_q     <= '0;
            visible_q     <= 1'b1;
            h_blank_q     <= 1'b0;
            v_blank_q     <= 1'b0;
            hsync_q       <= ~H_SYNC_POLARITY;
            vsync_q       <= ~V_SYNC_POLARITY;
            end_of_line_q <= 1'b0;
            frame_start_q <= 1'b0;
            scanline_q    <= 16'h0000;
        end else begin
            h_count_q     <= h_count_d;
            v_count_q     <= v_count_d;
            visible_q     <= visible_d;
            h_blank_q     <= h_blank_d;
            v_blank_q     <= v_blank_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            end_of_line_q <= end_of_line_d;
            frame_start_q <= frame_start_d;
            scanline_q    <= scanline_d;
        end
    end

    assign vt.h_count_o     = h_count_q;
    assign vt.v_count_o     = v_count_q;
    assign vt.visible_o     = visible_q;
    assign vt.h_blank_o     = h_blank_q;
    assign vt.v_blank_o     = v_blank_q;
    assign vt.hsync_o       = hsync_q;
    assign vt.vsync_o       = vsync_q;
    assign vt.end_of_line_o = end_of_line_q;
    assign vt.frame_start_o = frame_start_q;
    assign vt.scanline_o    = scanline_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - directed bench for video_timing_gen (default 640x480 and a small 16x10 raster)
module tb_video_timing_gen;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic pix_ce = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    video_timing_gen_if vt_d ();
    video_timing_gen_if vt_s ();

    // Default 800x525 raster.
    video_timing_gen u_dut_def (
        .clk      (clk),
        .reset_n  (reset_n),
        .pix_ce_i (pix_ce),
        .vt       (vt_d)
    );

    // Small raster: 24 columns (sync 18..20), 17 lines (sync 12..13), positive syncs.
    video_timing_gen #(
        .VISIBLE_WIDTH   (16),
        .VISIBLE_HEIGHT  (10),
        .H_FRONT_PORCH   (2),
        .H_SYNC_PULSE    (3),
        .H_BACK_PORCH    (3),
        .V_FRONT_PORCH   (2),
        .V_SYNC_PULSE    (2),
        .V_BACK_PORCH    (3),
        .H_SYNC_POLARITY (1'b1),
        .V_SYNC_POLARITY (1'b1)
    ) u_dut_small (
        .clk      (clk),
        .reset_n  (reset_n),
        .pix_ce_i (pix_ce),
        .vt       (vt_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int fs_cnt, vis_cnt, vs_cnt, vb_cnt, eol_cnt, hs_cnt, hb_cnt;
        int vs_min, vs_max, hs_min, hs_max, eol_k, fs_run, fs_run_max, unstable;
        logic [10:0] prev_h, prev_v;
        logic prev_hs, prev_vs, prev_vis, prev_ce;

        // ---------------- reset values ----------------
        reset_n = 1'b0;
        pix_ce  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_h",        32'(vt_d.h_count_o), 32'd0);
        check("rst_v",        32'(vt_d.v_count_o), 32'd0);
        check("rst_visible",  32'(vt_d.visible_o), 32'd1);
        check("rst_hblank",   32'(vt_d.h_blank_o), 32'd0);
        check("rst_vblank",   32'(vt_d.v_blank_o), 32'd0);
        check("rst_hsync",    32'(vt_d.hsync_o), 32'd1);
        check("rst_vsync",    32'(vt_d.vsync_o), 32'd1);
        check("rst_eol",      32'(vt_d.end_of_line_o), 32'd0);
        check("rst_fs",       32'(vt_d.frame_start_o), 32'd0);
        check("rst_scanline", 32'(vt_d.scanline_o), 32'h0000);
        check("rst_s_hsync",  32'(vt_s.hsync_o), 32'd0);
        check("rst_s_vsync",  32'(vt_s.vsync_o), 32'd0);

        // ---------------- small raster: two full frames ----------------
        reset_n = 1'b1;
        pix_ce  = 1'b1;
        fs_cnt = 0; vis_cnt = 0; vs_cnt = 0; vb_cnt = 0; eol_cnt = 0; hs_cnt = 0;
        vs_min = 4096; vs_max = -1; hs_min = 4096; hs_max = -1;
        for (int k = 1; k <= 816; k++) begin
            @(negedge clk);
            if (k == 1) check("s_first_h", 32'(vt_s.h_count_o), 32'd1);
            if (k == 408) begin
                check("s_fs_at_wrap", 32'(vt_s.frame_start_o), 32'd1);
                check("s_h_at_wrap",  32'(vt_s.h_count_o), 32'd0);
                check("s_v_at_wrap",  32'(vt_s.v_count_o), 32'd0);
            end
            if (k == 409) check("s_fs_one_clk", 32'(vt_s.frame_start_o), 32'd0);
            if (vt_s.frame_start_o) fs_cnt++;
            if (vt_s.visible_o) vis_cnt++;
            if (vt_s.v_blank_o) vb_cnt++;
            if (vt_s.end_of_line_o) eol_cnt++;
            if (vt_s.vsync_o) begin
                vs_cnt++;
                if (int'(vt_s.v_count_o) < vs_min) vs_min = int'(vt_s.v_count_o);
                if (int'(vt_s.v_count_o) > vs_max) vs_max = int'(vt_s.v_count_o);
            end
            if (vt_s.hsync_o) begin
                hs_cnt++;
                if (int'(vt_s.h_count_o) < hs_min) hs_min = int'(vt_s.h_count_o);
                if (int'(vt_s.h_count_o) > hs_max) hs_max = int'(vt_s.h_count_o);
            end
        end
        check("s_fs_count",   32'(fs_cnt), 32'd2);
        check("s_visible",    32'(vis_cnt), 32'd320);
        check("s_vblank",     32'(vb_cnt), 32'd336);
        check("s_eol_count",  32'(eol_cnt), 32'd34);
        check("s_vsync_cnt",  32'(vs_cnt), 32'd96);
        check("s_vsync_min",  32'(vs_min), 32'd12);
        check("s_vsync_max",  32'(vs_max), 32'd13);
        check("s_hsync_cnt",  32'(hs_cnt), 32'd102);
        check("s_hsync_min",  32'(hs_min), 32'd18);
        check("s_hsync_max",  32'(hs_max), 32'd20);

        // ---------------- small raster: pix_ce alternating 1/0 ----------------
        fs_cnt = 0; fs_run = 0; fs_run_max = 0; unstable = 0;
        prev_h = vt_s.h_count_o; prev_v = vt_s.v_count_o;
        prev_hs = vt_s.hsync_o; prev_vs = vt_s.vsync_o; prev_vis = vt_s.visible_o;
        for (int i = 0; i < 816; i++) begin
            pix_ce = ((i % 2) == 0);
            prev_ce = pix_ce;
            @(negedge clk);
            if (!prev_ce) begin
                if (vt_s.h_count_o !== prev_h || vt_s.v_count_o !== prev_v ||
                    vt_s.hsync_o !== prev_hs || vt_s.vsync_o !== prev_vs ||
                    vt_s.visible_o !== prev_vis || vt_s.frame_start_o !== 1'b0)
                    unstable++;
            end
            if (vt_s.frame_start_o) begin
                fs_cnt++;
                fs_run++;
                if (fs_run > fs_run_max) fs_run_max = fs_run;
            end else begin
                fs_run = 0;
            end
            if (i == 47) begin
                check("dbl_line_h", 32'(vt_s.h_count_o), 32'd0);
                check("dbl_line_v", 32'(vt_s.v_count_o), 32'd1);
            end
            prev_h = vt_s.h_count_o; prev_v = vt_s.v_count_o;
            prev_hs = vt_s.hsync_o; prev_vs = vt_s.vsync_o; prev_vis = vt_s.visible_o;
        end
        check("dbl_unstable", 32'(unstable), 32'd0);
        check("dbl_fs_count", 32'(fs_cnt), 32'd1);
        check("dbl_fs_width", 32'(fs_run_max), 32'd1);
        check("dbl_end_h",    32'(vt_s.h_count_o), 32'd0);
        check("dbl_end_v",    32'(vt_s.v_count_o), 32'd0);

        // ---------------- default raster: line 0 ----------------
        pix_ce  = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        pix_ce  = 1'b1;
        hs_cnt = 0; hs_min = 4096; hs_max = -1; hb_cnt = 0; eol_cnt = 0; eol_k = -1; vis_cnt = 0;
        for (int k = 1; k <= 800; k++) begin
            @(negedge clk);
            if (vt_d.hsync_o === 1'b0) begin
                hs_cnt++;
                if (int'(vt_d.h_count_o) < hs_min) hs_min = int'(vt_d.h_count_o);
                if (int'(vt_d.h_count_o) > hs_max) hs_max = int'(vt_d.h_count_o);
            end
            if (vt_d.h_blank_o) hb_cnt++;
            if (vt_d.visible_o) vis_cnt++;
            if (vt_d.end_of_line_o) begin
                eol_cnt++;
                eol_k = k;
            end
        end
        check("d_hsync_cnt", 32'(hs_cnt), 32'd96);
        check("d_hsync_min", 32'(hs_min), 32'd656);
        check("d_hsync_max", 32'(hs_max), 32'd751);
        check("d_hblank",    32'(hb_cnt), 32'd160);
        check("d_visible",   32'(vis_cnt), 32'd640);
        check("d_eol_count", 32'(eol_cnt), 32'd1);
        check("d_eol_at",    32'(eol_k), 32'd799);
        check("d_wrap_h",    32'(vt_d.h_count_o), 32'd0);
        check("d_wrap_v",    32'(vt_d.v_count_o), 32'd1);

        // Advance to v=10, h=5 (8005 edges from reset).
        repeat (7205) @(negedge clk);
        check("d_sl_h",        32'(vt_d.h_count_o), 32'd5);
        check("d_sl_v",        32'(vt_d.v_count_o), 32'd10);
        check("d_scanline_10", 32'(vt_d.scanline_o), 32'h000A);
        check("d_vsync_idle",  32'(vt_d.vsync_o), 32'd1);

        // ---------------- reset during the small raster's vsync line ----------------
        pix_ce  = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        pix_ce  = 1'b1;
        repeat (293) @(negedge clk);
        check("s_pre_v",        32'(vt_s.v_count_o), 32'd12);
        check("s_pre_vsync",    32'(vt_s.vsync_o), 32'd1);
        check("s_scanline_vb",  32'(vt_s.scanline_o), 32'h800C);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_s_vsync",    32'(vt_s.vsync_o), 32'd0);
        check("ar_s_h",        32'(vt_s.h_count_o), 32'd0);
        check("ar_s_v",        32'(vt_s.v_count_o), 32'd0);
        check("ar_s_visible",  32'(vt_s.visible_o), 32'd1);
        check("ar_s_scanline", 32'(vt_s.scanline_o), 32'h0000);
        check("ar_s_fs",       32'(vt_s.frame_start_o), 32'd0);
        check("ar_d_vsync",    32'(vt_d.vsync_o), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_s_h", 32'(vt_s.h_count_o), 32'd5);
        check("post_s_v", 32'(vt_s.v_count_o), 32'd0);
        check("post_d_h", 32'(vt_d.h_count_o), 32'd5);
        check("post_d_v", 32'(vt_d.v_count_o), 32'd0);
        check("post_fs",  32'(vt_s.frame_start_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard time bound for the whole run.
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
